// File: rtl/anb_rd_splitter.sv
// -----------------------------------------------------------------------------
// anb_rd_splitter
//
// Splits one upstream read request (address + byte length) into downstream
// sub-requests. No sub-request crosses a BOUNDARY-aligned address, and none is
// longer than MAX_BURST bytes. Each issued sub-request pushes a one-bit tag
// ("this is the final piece") into a small FIFO. The tag is popped on the last
// beat of that sub-request's data, which lets s_last mark only the true end of
// the original request. Read data passes straight through, combinationally.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_addr, s_len, s_avalid/aready  upstream request channel
//   s_data, s_last, s_valid/ready   upstream read-data channel
//   m_addr, m_len, m_avalid/aready  downstream sub-request channel (registered)
//   m_data, m_last, m_valid/ready   downstream read-data channel
//   err                             sticky: zero-length request, or data seen
//                                   while no sub-request was outstanding
// -----------------------------------------------------------------------------
module anb_rd_splitter #(
   parameter int ADDR_W    = 64,
   parameter int LEN_W     = 14,
   parameter int DATA_W    = 128,
   parameter int BOUNDARY  = 4096,
   parameter int MAX_BURST = 4096,
   parameter int TAG_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [LEN_W-1:0]  s_len,
   input  logic              s_avalid,
   output logic              s_aready,
   output logic [DATA_W-1:0] s_data,
   output logic              s_last,
   output logic              s_valid,
   input  logic              s_ready,
   output logic [ADDR_W-1:0] m_addr,
   output logic [LEN_W-1:0]  m_len,
   output logic              m_avalid,
   input  logic              m_aready,
   input  logic [DATA_W-1:0] m_data,
   input  logic              m_last,
   input  logic              m_valid,
   output logic              m_ready,
   output logic              err
);

   localparam int BW   = $clog2(BOUNDARY);
   localparam int MW   = $clog2(MAX_BURST);
   localparam int PW   = $clog2(TAG_DEPTH);
   localparam int CNTW = PW + 1;
   // The chunk arithmetic must hold the largest of len, BOUNDARY and MAX_BURST
   // without truncation, so it is sized one bit wider than the widest of them.
   localparam int CW0  = (LEN_W > BW) ? LEN_W : BW;
   localparam int CW   = ((CW0 > MW) ? CW0 : MW) + 1;

   typedef enum logic [0:0] {IDLE, SPLIT} state_t;

   // Length of the next sub-request: min(rem, bytes left to boundary, MAX_BURST).
   // The result never exceeds rem, so narrowing it back to LEN_W is lossless.
   function automatic logic [LEN_W-1:0] calc_chunk(input logic [BW-1:0]    offs,
                                                   input logic [LEN_W-1:0] rem);
      logic [CW-1:0] to_bnd;
      logic [CW-1:0] lim;
      to_bnd = CW'(BOUNDARY) - CW'(offs);
      lim    = CW'(rem);
      if (to_bnd < lim)         lim = to_bnd;
      if (CW'(MAX_BURST) < lim) lim = CW'(MAX_BURST);
      return lim[LEN_W-1:0];
   endfunction

   state_t              state_q,    state_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]    rem_q,      rem_d;
   logic [ADDR_W-1:0]   m_addr_q,   m_addr_d;
   logic [LEN_W-1:0]    m_len_q,    m_len_d;
   logic                m_avalid_q, m_avalid_d;
   logic                err_q,      err_d;
   logic [PW-1:0]       wr_ptr_q,   wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q,   rd_ptr_d;
   logic [CNTW-1:0]     count_q,    count_d;
   logic                tag_mem_q [TAG_DEPTH];

   logic                push, pop, fifo_empty, full_d, is_final, head_final;
   logic [ADDR_W-1:0]   next_addr;
   logic [LEN_W-1:0]    next_rem;

   // ---------------- tag FIFO control ----------------
   assign push       = m_avalid_q && m_aready;
   assign fifo_empty = (count_q == '0);
   assign head_final = !fifo_empty && tag_mem_q[rd_ptr_q];
   // A stray last beat with no outstanding tag must not underflow the FIFO.
   assign pop        = m_valid && s_ready && m_last && !fifo_empty;
   // m_len_q already holds the chunk of the sub-request on offer.
   assign is_final   = (m_len_q == rem_q);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CNTW'(push) - CNTW'(pop);
      full_d   = (count_d == CNTW'(TAG_DEPTH));
   end

   // ---------------- request FSM ----------------
   assign next_addr = cur_addr_q + ADDR_W'(m_len_q);   // wraps modulo 2^ADDR_W
   assign next_rem  = rem_q - m_len_q;

   always_comb begin
      // NOTE: every variable gets a default here so no path leaves one
      // unassigned; otherwise synthesis would infer a latch.
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      rem_d      = rem_q;
      m_addr_d   = m_addr_q;
      m_len_d    = m_len_q;
      m_avalid_d = m_avalid_q;
      err_d      = err_q;

      if (m_valid && fifo_empty) err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (s_avalid && s_aready) begin
               if (s_len == '0) begin
                  err_d = 1'b1;
               end else begin
                  state_d    = SPLIT;
                  cur_addr_d = s_addr;
                  rem_d      = s_len;
                  m_addr_d   = s_addr;
                  m_len_d    = calc_chunk(s_addr[BW-1:0], s_len);
                  m_avalid_d = !full_d;
               end
            end
         end
         SPLIT: begin
            if (push && is_final) begin
               state_d    = IDLE;
               m_avalid_d = 1'b0;
            end else begin
               if (push) begin
                  cur_addr_d = next_addr;
                  rem_d      = next_rem;
                  m_addr_d   = next_addr;
                  m_len_d    = calc_chunk(next_addr[BW-1:0], next_rem);
               end
               // Without a push the count cannot grow, so an asserted valid
               // is never withdrawn before its handshake.
               m_avalid_d = !full_d;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cur_addr_q <= '0;
         rem_q      <= '0;
         m_addr_q   <= '0;
         m_len_q    <= '0;
         m_avalid_q <= 1'b0;
         err_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         rem_q      <= rem_d;
         m_addr_q   <= m_addr_d;
         m_len_q    <= m_len_d;
         m_avalid_q <= m_avalid_d;
         err_q      <= err_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // NOTE: tag storage is deliberately not reset; an entry is only read while
   // count_q says it is valid, and resetting the pointers empties the FIFO.
   always_ff @(posedge clk) begin
      if (push) tag_mem_q[wr_ptr_q] <= is_final;
   end

   // ---------------- outputs ----------------
   // Gated by rst_n so ready is low during reset and high in the first cycle
   // after release.
   assign s_aready = rst_n && (state_q == IDLE);
   assign m_addr   = m_addr_q;
   assign m_len    = m_len_q;
   assign m_avalid = m_avalid_q;
   assign err      = err_q;

   assign s_data   = m_data;
   assign s_valid  = m_valid;
   assign m_ready  = s_ready;
   assign s_last   = m_last && head_final;

endmodule

// File: tb/tb_anb_rd_splitter.sv
// -----------------------------------------------------------------------------
// tb_anb_rd_splitter
//
// Directed stimulus with a scoreboard. Expected sub-requests and expected data
// beats go into queues as stimulus is issued. A monitor on the falling edge pops
// and compares them whenever a handshake is pending. The DUT is built with
// TAG_DEPTH=2 so that tag-FIFO backpressure can be reached.
// -----------------------------------------------------------------------------
module tb_anb_rd_splitter;

   localparam int ADDR_W = 64;
   localparam int LEN_W  = 14;
   localparam int DATA_W = 128;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } req_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   logic              clk, rst_n;
   logic [ADDR_W-1:0] s_addr;
   logic [LEN_W-1:0]  s_len;
   logic              s_avalid, s_aready;
   logic [DATA_W-1:0] s_data;
   logic              s_last, s_valid, s_ready;
   logic [ADDR_W-1:0] m_addr;
   logic [LEN_W-1:0]  m_len;
   logic              m_avalid, m_aready;
   logic [DATA_W-1:0] m_data;
   logic              m_last, m_valid, m_ready;
   logic              err;

   req_t  exp_req[$];
   beat_t exp_beat[$];
   int    n_pass  = 0;
   int    n_total = 0;

   anb_rd_splitter #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W),
      .BOUNDARY(4096), .MAX_BURST(4096), .TAG_DEPTH(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_addr(s_addr), .s_len(s_len), .s_avalid(s_avalid), .s_aready(s_aready),
      .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
      .m_addr(m_addr), .m_len(m_len), .m_avalid(m_avalid), .m_aready(m_aready),
      .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin : mon
      req_t  r;
      beat_t b;
      if (m_avalid && m_aready) begin
         if (exp_req.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_subreq: got addr=0x%0h len=0x%0h, expected none", m_addr, m_len);
         end else begin
            r = exp_req.pop_front();
            check("subreq_addr", 128'(m_addr), 128'(r.addr));
            check("subreq_len",  128'(m_len),  128'(r.len));
         end
      end
      if (s_valid && s_ready) begin
         if (exp_beat.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_beat: got data=0x%0h, expected none", s_data);
         end else begin
            b = exp_beat.pop_front();
            check("beat_data", s_data, b.data);
            check("beat_last", 128'(s_last), 128'(b.last));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
      req_t r;
      r.addr = a;
      r.len  = l;
      exp_req.push_back(r);
   endtask

   task automatic send_req(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
      logic done;
      done     = 1'b0;
      s_addr   = a;
      s_len    = l;
      s_avalid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (s_aready) begin
            tick();
            done = 1'b1;
         end
      end
      s_avalid = 1'b0;
      if (!done) begin
         n_total++;
         $display("FAIL send_req_timeout: got no s_aready, expected acceptance of addr=0x%0h", a);
      end
   endtask

   task automatic wait_reqs();
      for (int i = 0; i < 50 && exp_req.size() != 0; i++) tick();
      check("subreqs_drained", 128'(exp_req.size()), 128'(0));
   endtask

   task automatic beat(input logic [DATA_W-1:0] d, input logic ml, input logic exp_last);
      beat_t b;
      b.data = d;
      b.last = exp_last;
      exp_beat.push_back(b);
      m_data  = d;
      m_last  = ml;
      m_valid = 1'b1;
      tick();
      m_valid = 1'b0;
      m_last  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed test sequence ----------------
   initial begin
      rst_n = 1'b0; s_avalid = 1'b0; s_addr = '0; s_len = '0; s_ready = 1'b1;
      m_aready = 1'b1; m_valid = 1'b0; m_data = '0; m_last = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_aready", 128'(s_aready), 128'(0));
      check("rst_m_avalid", 128'(m_avalid), 128'(0));
      check("rst_m_addr",   128'(m_addr),   128'(0));
      check("rst_m_len",    128'(m_len),    128'(0));
      check("rst_err",      128'(err),      128'(0));
      rst_n = 1'b1;
      #1;
      check("aready_after_reset", 128'(s_aready), 128'(1));
      tick();

      // Boundary split: 0x0FF0 + 0x40 -> (0x0FF0,0x10), (0x1000,0x30)
      push_req(64'h0FF0, 14'h10);
      push_req(64'h1000, 14'h30);
      send_req(64'h0FF0, 14'h40);
      wait_reqs();
      beat(128'hA1, 1'b1, 1'b0);
      beat(128'hA2, 1'b0, 1'b0);
      beat(128'hA3, 1'b0, 1'b0);
      beat(128'hA4, 1'b1, 1'b1);
      check("bnd_err", 128'(err), 128'(0));
      check("bnd_aready_idle", 128'(s_aready), 128'(1));

      // Aligned request: one sub-request, s_last follows m_last
      push_req(64'h2000, 14'h1000);
      send_req(64'h2000, 14'h1000);
      wait_reqs();
      beat(128'hB1, 1'b0, 1'b0);
      beat(128'hB2, 1'b1, 1'b1);

      // Address wrap at 2^64, split at the wrapped boundary
      push_req(64'hFFFF_FFFF_FFFF_FFF0, 14'h10);
      push_req(64'h0, 14'h10);
      send_req(64'hFFFF_FFFF_FFFF_FFF0, 14'h20);
      wait_reqs();
      beat(128'hC1, 1'b1, 1'b0);
      beat(128'hC2, 1'b1, 1'b1);

      // Backpressure with two tags: third sub-request waits for a pop
      push_req(64'h0,    14'h1000);
      push_req(64'h1000, 14'h1000);
      push_req(64'h2000, 14'h1000);
      send_req(64'h0, 14'h3000);
      repeat (6) tick();
      check("bp_pending",    128'(exp_req.size()), 128'(1));
      check("bp_avalid_low", 128'(m_avalid), 128'(0));
      check("bp_aready_low", 128'(s_aready), 128'(0));
      beat(128'hD1, 1'b1, 1'b0);
      check("bp_avalid_reassert", 128'(m_avalid), 128'(1));
      check("bp_addr_third",      128'(m_addr),   128'(64'h2000));
      wait_reqs();
      beat(128'hD2, 1'b1, 1'b0);
      beat(128'hD3, 1'b1, 1'b1);
      check("bp_err", 128'(err), 128'(0));

      // Zero length: consumed in IDLE, no sub-request, sticky err
      send_req(64'h40, 14'h0);
      check("zl_err",        128'(err),      128'(1));
      check("zl_aready",     128'(s_aready), 128'(1));
      check("zl_avalid",     128'(m_avalid), 128'(0));
      repeat (3) tick();
      check("zl_avalid_later", 128'(m_avalid), 128'(0));
      check("zl_err_sticky",   128'(err),      128'(1));
      rst_n = 1'b0;
      #1;
      check("zl_err_cleared", 128'(err), 128'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // Data beat with no outstanding tag: passes with s_last=0, sets err
      beat(128'hE1, 1'b1, 1'b0);
      check("empty_beat_err", 128'(err), 128'(1));

      // Reset mid-split during the second sub-request
      m_aready = 1'b0;
      push_req(64'h0, 14'h1000);
      send_req(64'h0, 14'h2000);
      tick();
      m_aready = 1'b1;
      tick();
      m_aready = 1'b0;
      check("ms_second_valid", 128'(m_avalid), 128'(1));
      check("ms_second_addr",  128'(m_addr),   128'(64'h1000));
      rst_n = 1'b0;
      #1;
      check("ms_avalid_rst", 128'(m_avalid), 128'(0));
      check("ms_err_rst",    128'(err),      128'(0));
      check("ms_aready_rst", 128'(s_aready), 128'(0));
      check("ms_addr_rst",   128'(m_addr),   128'(0));
      tick();
      rst_n = 1'b1;
      #1;
      check("ms_aready_release", 128'(s_aready), 128'(1));
      m_aready = 1'b1;
      tick();
      // Stale tags from the abandoned request would turn this s_last to 0
      push_req(64'h5000, 14'h1000);
      send_req(64'h5000, 14'h1000);
      wait_reqs();
      beat(128'hF1, 1'b1, 1'b1);
      check("ms_err_after", 128'(err), 128'(0));

      tick();
      check("beats_drained", 128'(exp_beat.size()), 128'(0));
      check("reqs_drained",  128'(exp_req.size()),  128'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
